// File: rtl/uart_imem_loader_ctrl.sv
// -----------------------------------------------------------------------------
// uart_imem_loader_ctrl
// Boot-load sequencer between a UART receiver and the instruction memory.
// Received bytes are packed little-endian into 32-bit words and written to
// consecutive word addresses while the core is held in reset. The word
// 0xFFFFFFFF terminates the load and releases the core. A BREAK restarts.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   rx_valid    one-cycle strobe, rx_data holds a received byte
//   rx_data     received byte
//   rx_break    one-cycle strobe, BREAK seen on the line
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  word being written
//   core_rst    active-high hold-in-reset for the CPU
//   write_done  load complete, core running
//   load_err    image exceeded memory capacity
//   word_count  words written in the current load (saturates at 2^ADDR_W)
// -----------------------------------------------------------------------------
module uart_imem_loader_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              write_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
    localparam logic [ADDR_W:0] WC_ONE    = (ADDR_W + 1)'(1);
    localparam logic [31:0]     TERM_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;       // lower three lanes; lane 3 comes straight from rx_data
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                core_rst_q, core_rst_d;
    logic                write_done_q, write_done_d;
    logic                load_err_q, load_err_d;

    logic                byte_acc_s;
    logic                word_full_s;
    logic [31:0]         full_word_s;
    logic                is_term_s;
    logic                has_room_s;
    logic                do_write_s;
    logic                tmo_armed_s;

    // A byte is taken only while loading and only when no BREAK competes with it.
    assign byte_acc_s  = (state_q == ST_LOAD) && rx_valid && !rx_break;
    assign word_full_s = byte_acc_s && (byte_idx_q == 2'd3);
    assign full_word_s = {rx_data, word_q};
    assign is_term_s   = (full_word_s == TERM_WORD);
    // The top bit of word_count is set only once the memory is full.
    assign has_room_s  = !word_count_q[ADDR_W];
    assign do_write_s  = word_full_s && !is_term_s && has_room_s;
    assign tmo_armed_s = (state_q == ST_LOAD) && (byte_idx_q != 2'd0);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: BREAK overrides everything, otherwise the 4th byte decides.
    always_comb begin
        state_d = state_q;
        if (rx_break) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (word_full_s && is_term_s) begin
                        state_d = ST_DONE;
                    end else if (word_full_s && !has_room_s) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Output decode from the next state so the status flags are registered.
    always_comb begin
        core_rst_d   = 1'b1;
        write_done_d = 1'b0;
        load_err_d   = 1'b0;
        case (state_d)
            ST_LOAD: begin
                core_rst_d   = 1'b1;
                write_done_d = 1'b0;
                load_err_d   = 1'b0;
            end
            ST_DONE: begin
                core_rst_d   = 1'b0;
                write_done_d = 1'b1;
                load_err_d   = 1'b0;
            end
            ST_ERR: begin
                core_rst_d   = 1'b1;
                write_done_d = 1'b0;
                load_err_d   = 1'b1;
            end
            default: begin
                core_rst_d   = 1'b1;
                write_done_d = 1'b0;
                load_err_d   = 1'b0;
            end
        endcase
    end

    // Datapath next-state: byte assembly, write issue, word counting, idle timeout.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        tmo_d        = tmo_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        word_count_d = word_count_q;
        if (rx_break) begin
            byte_idx_d   = 2'd0;
            word_d       = 24'd0;
            tmo_d        = {TW{1'b0}};
            imem_we_d    = 1'b0;
            imem_addr_d  = {ADDR_W{1'b0}};
            imem_wdata_d = 32'd0;
            word_count_d = {(ADDR_W + 1){1'b0}};
        end else begin
            // The count follows the write strobe by one cycle; writes are only
            // issued while there is room, so it cannot pass 2^ADDR_W.
            if (imem_we_q) begin
                word_count_d = word_count_q + WC_ONE;
            end else begin
                word_count_d = word_count_q;
            end
            if (byte_acc_s) begin
                byte_idx_d = byte_idx_q + 2'd1;
                tmo_d      = {TW{1'b0}};
                case (byte_idx_q)
                    2'd0:    word_d[7:0]   = rx_data;
                    2'd1:    word_d[15:8]  = rx_data;
                    2'd2:    word_d[23:16] = rx_data;
                    default: word_d        = word_q;
                endcase
                if (do_write_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = full_word_s;
                end else begin
                    imem_we_d    = 1'b0;
                end
            end else if (tmo_armed_s) begin
                if (tmo_q < TMO_MAX) begin
                    tmo_d = tmo_q + TMO_ONE;
                end else begin
                    tmo_d = tmo_q;
                end
                // Discard on the edge where the idle count reaches TIMEOUT.
                if (tmo_q == TMO_LAST) begin
                    byte_idx_d = 2'd0;
                    word_d     = 24'd0;
                end else begin
                    byte_idx_d = byte_idx_q;
                end
            end else begin
                tmo_d = {TW{1'b0}};
            end
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_idx_q   <= 2'd0;
            word_q       <= 24'd0;
            tmo_q        <= {TW{1'b0}};
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 32'd0;
            word_count_q <= {(ADDR_W + 1){1'b0}};
            core_rst_q   <= 1'b1;
            write_done_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            word_count_q <= word_count_d;
            core_rst_q   <= core_rst_d;
            write_done_q <= write_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign write_done = write_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule
